// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic MULT = 1'b0;
    localparam logic DIV  = 1'b1;

    localparam int ITER_DEFAULT = 32;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // |-2^31| comes out as 0x80000000, which is exact when read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV: one shared 64-bit shift register and 33-bit adder,
// sequenced by a start/done handshake; results land in HI/LO.
//
// state | meaning
// IDLE  | waiting for start; operands, signs and op latched on accept
// RUN   | one multiplier/quotient bit per cycle, ITER cycles
// FIX   | apply result signs, write hi/lo
// DONE  | done pulse for one cycle
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    localparam int CNT_W = $clog2(ITER);

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic               sign_hi_q, sign_hi_d;
    logic               sign_lo_q, sign_lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [63:0]        acc_q, acc_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               dz_q, dz_d;

    logic [32:0]        op_x, op_y, sum;
    logic               sub;
    logic [63:0]        step_acc;
    logic [63:0]        prod_signed;

    // MULT adds the multiplicand into the upper word; DIV trial-subtracts the
    // divisor from the remainder shifted left by one dividend bit.
    always_comb begin
        sub  = (op_q == DIV);
        op_y = {1'b0, opnd_q};
        op_x = sub ? {acc_q[63:32], acc_q[31]} : {1'b0, acc_q[63:32]};
        sum  = op_x + (sub ? ~op_y : op_y) + {32'd0, sub};
        if (sub)
            step_acc = {(sum[32] ? op_x[31:0] : sum[31:0]), acc_q[30:0], ~sum[32]};
        else
            step_acc = {(acc_q[0] ? sum : op_x), acc_q[31:1]};
    end

    assign prod_signed = sign_lo_q ? neg64(acc_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_hi_d = sign_hi_q;
        sign_lo_d = sign_lo_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    sign_lo_d = a[31] ^ b[31];
                    sign_hi_d = (op == DIV) ? a[31] : (a[31] ^ b[31]);
                    cnt_d     = '0;
                    dz_d      = (op == DIV) && (b == 32'd0);
                    opnd_d    = (op == DIV) ? mag32(b) : mag32(a);
                    acc_d     = {32'd0, (op == DIV) ? mag32(a) : mag32(b)};
                    state_d   = ((op == DIV) && (b == 32'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1))
                    state_d = FIX;
            end
            FIX: begin
                if (op_q == DIV) begin
                    lo_d = sign_lo_q ? neg32(acc_q[31:0])  : acc_q[31:0];
                    hi_d = sign_hi_q ? neg32(acc_q[63:32]) : acc_q[63:32];
                end else begin
                    lo_d = prod_signed[31:0];
                    hi_d = prod_signed[63:32];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            sign_hi_q <= 1'b0;
            sign_lo_q <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sign_hi_q <= sign_hi_d;
            sign_lo_q <= sign_lo_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = (state_q == RUN) || (state_q == FIX);
    assign done     = (state_q == DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit for the multicycle CPU. It is sequenced by the main control FSM through a start/done handshake and writes the HI/LO result registers. Operands come from the A/B register outputs. While the unit is busy, the control FSM holds in a wait state. One shared 32-iteration shift engine implements both signed multiplication and signed division.

## Interface
- `ITER`, default 32: iteration count; must equal the operand width.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled on the rising edge; accepted only in IDLE.
- `op`  in  1: operation select. 0 = MULT, 1 = DIV. Sampled with `start`.
- `a`  in  32: signed multiplicand or dividend. Sampled with `start`.
- `b`  in  32: signed multiplier or divisor. Sampled with `start`.
- `busy`  out  1: high in the RUN and FIX states.
- `done`  out  1: one-cycle pulse; HI/LO and `div_zero` are valid in that cycle.
- `hi`  out  32: MULT: upper product word. DIV: remainder.
- `lo`  out  32: MULT: lower product word. DIV: quotient.
- `div_zero`  out  1: set when the last accepted DIV had `b` = 0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start` = 1:
  - Latch `op`.
  - Latch the magnitudes |a| and |b| as 32-bit unsigned values; |−2^31| = 0x80000000 is exact.
  - Latch the result sign. MULT: sign(a) XOR sign(b). DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the iteration counter and clear `div_zero`.
  - Next state is RUN, or DONE when DIV with `b` = 0.
- RUN, MULT: shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, DIV: restoring division.
  - 33-bit partial remainder; one quotient bit per cycle, MSB first.
  - Trial subtract each cycle; on a negative result, restore the remainder and shift in quotient bit 0.
- The counter increments each RUN cycle. After `ITER` iterations the state goes to FIX.
- FIX:
  - Two's-complement-negate each result part whose latched sign is 1.
  - Write `hi`/`lo`, then go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle, then return to IDLE.
  - `start` is ignored in this state.
- Division semantics: quotient truncates toward zero; the remainder takes the dividend's sign.
- 0x80000000 / −1 gives `lo` = 0x80000000, `hi` = 0 (wraps naturally; no special case).
- Divide by zero:
  - `div_zero` = 1.
  - `hi`/`lo` keep their previous values.
  - `done` pulses; no RUN cycles occur.
- `start` outside IDLE is ignored. Operands are never re-sampled mid-operation.
- `hi`, `lo` and `div_zero` hold their values until the next completion or reset.

## Timing
- Let E0 be the edge that accepts `start`.
- Normal operation:
  - `busy` = 1 from E0 until E33.
  - RUN occupies the cycles after edges E0 through E31.
  - FIX is the cycle after E32.
  - `hi`/`lo` update at E33.
  - `done` = 1 in the cycle after E33 (between E33 and E34).
  - Back in IDLE after E34. Total latency: 34 cycles.
- Divide by zero: `done` = 1 in the cycle after E0; `busy` never asserts.
- Back-to-back: the earliest next accept is E35.
- Reset, asynchronous and valid at any point, including mid-RUN:
  - State returns to IDLE immediately.
  - `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, `div_zero` = 0, counter = 0.
- Outputs are registered. There is no combinational path from any input to any output.

## Structure
- A shared package `mult_div_pkg` holds:
  - the state enum {IDLE, RUN, FIX, DONE};
  - the op constants MULT = 0, DIV = 1;
  - the `ITER` default.
- Single module. The MULT and DIV engines share the 64-bit shift register and the 33-bit adder/subtractor; no sub-module is needed.

## Test plan
- MULT, `a` = 7, `b` = −3:
  - `done` pulses exactly 34 cycles after the accept edge.
  - `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- MULT, `a` = 0x80000000, `b` = 0x80000000: `hi` = 0x40000000, `lo` = 0x00000000.
- DIV, `a` = −7, `b` = 2: `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF, `div_zero` = 0.
- DIV, `a` = 0x80000000, `b` = −1: `lo` = 0x80000000, `hi` = 0.
- DIV by zero:
  - Preload `hi`/`lo` via MULT 3×5 (`lo` = 15, `hi` = 0).
  - Then DIV 5/0: `done` pulses 1 cycle after accept, `busy` stays 0, `div_zero` = 1, and `hi`/`lo` stay 0/15.
- Start while busy, then reset mid-RUN:
  - A second `start` at cycle 5 is ignored; the first result completes unchanged.
  - Assert `reset` at cycle 10 of a new op: `busy`, `done`, `hi`, `lo` all become 0 immediately, and a subsequent op completes correctly.
